// File: rtl/byte_stream_server.sv
// Byte streamer: arms on a trigger byte and pushes a memory image to uart_tx.
// Supports abort, re-arm/single-shot and progress counting.
module byte_stream_server #(
  parameter int          DEPTH   = 1300,
  parameter int          ADDR_W  = $clog2(DEPTH),
  parameter logic [7:0]  TRIGGER = 8'hAA,
  parameter logic [7:0]  ABORT   = 8'h55,
  parameter bit          REARM   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   sent_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH-1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   sent_q, sent_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        txd_q, txd_d;
  logic              done_q, done_d;
  logic              abt_q, abt_d;
  logic              pend_q, pend_d;
  logic              trig, abrt;
  logic [ADDR_W:0]   n_clamp;

  assign trig    = rx_valid && (rx_data == TRIGGER);
  assign abrt    = rx_valid && (rx_data == ABORT);
  assign n_clamp = (len > DEPTH_L) ? DEPTH_L : len;

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign rd_en    = (state_q == S_FETCH);
  assign rd_addr  = addr_q;
  // A pending abort suppresses any further start pulse.
  assign tx_start = (state_q == S_SEND) && !tx_busy && !pend_q;
  assign tx_data  = txd_q;
  assign done     = done_q;
  assign aborted  = abt_q;
  assign sent_cnt = sent_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    sent_d  = sent_q;
    addr_d  = addr_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    abt_d   = abt_q;
    pend_d  = pend_q;
    if (busy && abrt) pend_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          n_d     = n_clamp;
          sent_d  = '0;
          abt_d   = 1'b0;
          addr_d  = '0;
          state_d = (n_clamp == '0) ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        txd_d   = rd_data;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (pend_q) begin
          state_d = S_FIN;
        end else if (!tx_busy) begin
          if (sent_q != n_q) sent_d = sent_q + 1'b1;
          if (addr_q != LAST_A) addr_d = addr_q + 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!tx_busy)
          state_d = (sent_q == n_q || pend_q) ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        done_d  = 1'b1;
        abt_d   = pend_q;
        pend_d  = 1'b0;
        state_d = REARM ? S_IDLE : S_DONE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      sent_q  <= '0;
      addr_q  <= '0;
      txd_q   <= '0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      sent_q  <= sent_d;
      addr_q  <= addr_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_byte_stream_server.sv
// Bench for byte_stream_server: table-driven runs, corner sequences and
// randomized transfers checked against a stream-level reference.
module tb_byte_stream_server;

  localparam int         DEPTH = 1300;
  localparam int         AW    = 11;
  localparam logic [7:0] TRIG  = 8'hAA;
  localparam logic [7:0] ABRT  = 8'h55;

  logic          clk = 1'b0;
  logic          rst, rst2;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW:0]   len;

  logic          rd_en, tx_start, tx_busy, busy, done, aborted;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data, tx_data;
  logic [AW:0]   sent_cnt;

  logic          s_rd_en, s_tx_start, s_tx_busy, s_busy, s_done, s_aborted;
  logic [AW-1:0] s_rd_addr;
  logic [7:0]    s_rd_data, s_tx_data;
  logic [AW:0]   s_sent;

  always #5 clk = ~clk;

  byte_stream_server #(.DEPTH(DEPTH), .REARM(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .len(len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .done(done), .aborted(aborted), .sent_cnt(sent_cnt)
  );

  byte_stream_server #(.DEPTH(DEPTH), .REARM(1'b0)) dut_ss (
    .clk(clk), .rst(rst2), .rx_data(rx_data), .rx_valid(rx_valid),
    .len(len), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .tx_data(s_tx_data), .tx_start(s_tx_start), .tx_busy(s_tx_busy),
    .busy(s_busy), .done(s_done), .aborted(s_aborted), .sent_cnt(s_sent)
  );

  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (s_rd_en) s_rd_data <= mem[s_rd_addr];
  end

  // uart_tx stand-ins: busy from the cycle after start for busy_len cycles
  int busy_len = 2;
  int bcnt = 0, s_bcnt = 0;
  int n_start = 0, n_done = 0, viol = 0;
  int s_starts = 0, s_dones = 0, s_viol = 0;
  logic [7:0] rxq [$];
  logic [7:0] s_q [$];
  assign tx_busy   = (bcnt > 0);
  assign s_tx_busy = (s_bcnt > 0);

  always @(posedge clk) begin
    if (tx_start) begin
      if (tx_busy) viol++;
      rxq.push_back(tx_data);
      n_start++;
      bcnt <= busy_len;
    end else if (bcnt > 0) bcnt <= bcnt - 1;
    if (done) n_done++;
    if (s_tx_start) begin
      if (s_tx_busy) s_viol++;
      s_q.push_back(s_tx_data);
      s_starts++;
      s_bcnt <= 3;
    end else if (s_bcnt > 0) s_bcnt <= s_bcnt - 1;
    if (s_done) s_dones++;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int         l;
    int         ia;
    logic [7:0] ib;
    int         blen;
    int         exp_n;
    int         exp_ab;
  } vec_t;

  // Reference: stream = mem[0..k-1], k = min(len,DEPTH) or abort point
  function automatic int ref_n(input int l, input int ia, input logic [7:0] ib);
    int n = (l > DEPTH) ? DEPTH : l;
    if (ia > 0 && ib == ABRT && n > 0 && ia < n) return ia;
    return n;
  endfunction

  task automatic run(input string nm, input vec_t v);
    int cyc = 0, bad = 0, bound;
    bit inj = 0;
    int s0 = n_start, d0 = n_done;
    bound = (v.exp_n + 2) * (v.blen + 10) + 50;
    busy_len = v.blen;
    rxq.delete();
    @(negedge clk);
    len = v.l[AW:0];
    rx_data = TRIG;
    rx_valid = 1'b1;
    while (n_done == d0 && cyc < bound) begin
      @(negedge clk);
      rx_valid = 1'b0;
      cyc++;
      if (v.ia > 0 && !inj && (n_start - s0) >= v.ia) begin
        rx_data = v.ib;
        rx_valid = 1'b1;
        inj = 1;
      end
    end
    rx_valid = 1'b0;
    chk({nm, "_done_seen"}, int'(n_done > d0), 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < rxq.size() && i < v.exp_n; i++)
      if (rxq[i] !== mem[i]) bad++;
    chk({nm, "_nbytes"}, rxq.size(), v.exp_n);
    chk({nm, "_data"}, bad, 0);
    chk({nm, "_sent_cnt"}, int'(sent_cnt), v.exp_n);
    chk({nm, "_aborted"}, int'(aborted), v.exp_ab);
    chk({nm, "_done_pulses"}, n_done - d0, 1);
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    int n0, cyc;
    tbl[0] = '{1300, 0, 8'h00, 1, 1300, 0};
    tbl[1] = '{2000, 0, 8'h00, 2, 1300, 0};
    tbl[2] = '{10, 3, ABRT, 2, 3, 1};
    tbl[3] = '{1, 0, 8'h00, 3, 1, 0};
    tbl[4] = '{8, 2, TRIG, 55, 8, 0};
    tbl[5] = '{6, 6, ABRT, 1, 6, 1};
    tbl[6] = '{5, 1, ABRT, 4, 1, 1};
    for (int i = 0; i < DEPTH; i++) mem[i] = i[7:0];

    rst = 1'b1;
    rst2 = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    len = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_sent", int'(sent_cnt), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    rst = 1'b0;
    rst2 = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b1;
    n0 = 0;
    repeat (6) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (rd_en || busy) n0++;
    end
    chk("idle_no_fetch", n0, 0);

    run("rearm1", '{4, 0, 8'h00, 2, 4, 0});
    run("rearm2", '{4, 0, 8'h00, 2, 4, 0});
    repeat (20) @(negedge clk);
    chk("single_starts", s_starts, 4);
    chk("single_dones", s_dones, 1);
    n0 = 0;
    for (int i = 0; i < s_q.size() && i < 4; i++)
      if (s_q[i] !== mem[i]) n0++;
    chk("single_data", n0, 0);

    // trigger-to-start latency
    mem[0] = 8'h3C;
    busy_len = 2;
    len = 12'd3;
    rx_data = TRIG;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("lat_rd_en_t1", int'(rd_en), 1);
    chk("lat_rd_addr", int'(rd_addr), 0);
    @(negedge clk);
    chk("lat_no_start_t2", int'(tx_start), 0);
    @(negedge clk);
    chk("lat_start_t3", int'(tx_start), 1);
    chk("lat_tx_data", int'(tx_data), 8'h3C);
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("lat_finish", int'(busy), 0);

    // zero length: done two edges after trigger, no start
    n0 = n_start;
    len = '0;
    rx_data = TRIG;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("zero_done_t1", int'(done), 0);
    chk("zero_busy_t1", int'(busy), 1);
    @(negedge clk);
    chk("zero_done_t2", int'(done), 1);
    @(negedge clk);
    chk("zero_done_pulse", int'(done), 0);
    chk("zero_no_start", n_start - n0, 0);

    for (int i = 0; i < 7; i++) run($sformatf("vec%0d", i), tbl[i]);

    // reset while a start pulse is high
    busy_len = 2;
    n0 = n_start;
    len = 12'd20;
    rx_data = TRIG;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    cyc = 0;
    while (!((n_start - n0) >= 3 && tx_start) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_rst_reached", int'(tx_start), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_tx_start", int'(tx_start), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_sent", int'(sent_cnt), 0);
    repeat (5) @(negedge clk);
    chk("mid_rst_stay_idle", int'(busy), 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      rv.l    = ($urandom_range(0, 7) == 0) ? $urandom_range(1250, 1500)
                                            : $urandom_range(0, 40);
      rv.blen = $urandom_range(1, 6);
      rv.ia   = 0;
      rv.ib   = 8'h00;
      if (rv.l > 0 && $urandom_range(0, 1) == 1) begin
        rv.ia = $urandom_range(1, (rv.l > 40) ? 40 : rv.l);
        rv.ib = ($urandom_range(0, 2) == 0) ? TRIG : ABRT;
      end
      rv.exp_n  = ref_n(rv.l, rv.ia, rv.ib);
      rv.exp_ab = (rv.ia > 0 && rv.ib == ABRT) ? 1 : 0;
      run($sformatf("rnd%0d", r), rv);
    end

    chk("no_start_while_busy", viol, 0);
    chk("single_no_start_while_busy", s_viol, 0);
    chk("single_final_starts", s_starts, 4);
    chk("single_parked", int'(s_busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
